stage_sequencer: RTL

//  Parametrised successor of the two-stage filter/compare controller. Sequences
//  NUM_STAGES processing stages in a strict chain: stage k+1 starts only after

---
 rtl/stage_sequencer_if.sv | 38 +++
 rtl/stage_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// ============================================================================
//  Module      : stage_sequencer_if
//  Description : Control/status bundle between the stage sequencer and the
//                stage owners (request side = master, sequencer = slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface stage_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int IDX_W      = 2
);
    logic                  start;
    logic                  abort;
    logic                  clear_err;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_enable;
    logic [NUM_STAGES-1:0] stage_start;
    logic [IDX_W-1:0]      cur_stage;
    logic                  busy;
    logic                  seq_done;
    logic                  timeout_err;
    logic [IDX_W-1:0]      err_stage;

    modport master (
        output start, abort, clear_err, stage_done,
        input  stage_enable, stage_start, cur_stage, busy, seq_done,
               timeout_err, err_stage
    );

    modport slave (
        input  start, abort, clear_err, stage_done,
        output stage_enable, stage_start, cur_stage, busy, seq_done,
               timeout_err, err_stage
    );
endinterface

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ============================================================================
//  Module      : stage_sequencer
//  Description : Runs NUM_STAGES stages strictly in order with per-stage
//                watchdog, abort and sticky timeout status. Outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stage_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input wire logic         clk,
    input wire logic         reset,
    stage_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam bit                    c_wd_en    = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_W-1:0]  c_to_last  = (TIMEOUT_CYCLES > 0) ?
                                                   TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] c_first    = NUM_STAGES'(1);

    state_t                r_state,       w_state_nx;
    logic [IDX_W-1:0]      r_cur,         w_cur_nx;
    logic [NUM_STAGES-1:0] r_enable,      w_enable_nx;
    logic [NUM_STAGES-1:0] r_start_pls,   w_start_pls_nx;
    logic                  r_busy,        w_busy_nx;
    logic                  r_seq_done,    w_seq_done_nx;
    logic                  r_terr,        w_terr_nx;
    logic [IDX_W-1:0]      r_err_stage,   w_err_stage_nx;
    logic [TIMEOUT_W-1:0]  r_wd,          w_wd_nx;

    logic w_cur_done;
    logic w_wd_expire;

    // The enable vector is one-hot on the current stage, so masking with it
    // selects exactly the done bit of the active stage and ignores the rest.
    assign w_cur_done  = |(bus.stage_done & r_enable);
    assign w_wd_expire = c_wd_en && (r_wd == c_to_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_enable    <= '0;
            r_start_pls <= '0;
            r_busy      <= 1'b0;
            r_seq_done  <= 1'b0;
            r_terr      <= 1'b0;
            r_err_stage <= '0;
            r_wd        <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cur       <= w_cur_nx;
            r_enable    <= w_enable_nx;
            r_start_pls <= w_start_pls_nx;
            r_busy      <= w_busy_nx;
            r_seq_done  <= w_seq_done_nx;
            r_terr      <= w_terr_nx;
            r_err_stage <= w_err_stage_nx;
            r_wd        <= w_wd_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_cur_nx       = r_cur;
        w_enable_nx    = r_enable;
        w_start_pls_nx = '0;
        w_busy_nx      = r_busy;
        w_seq_done_nx  = 1'b0;
        w_terr_nx      = r_terr;
        w_err_stage_nx = r_err_stage;
        w_wd_nx        = r_wd;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nx     = ST_RUN;
                    w_cur_nx       = '0;
                    w_enable_nx    = c_first;
                    w_start_pls_nx = c_first;
                    w_busy_nx      = 1'b1;
                    w_wd_nx        = '0;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nx  = ST_IDLE;
                    w_cur_nx    = '0;
                    w_enable_nx = '0;
                    w_busy_nx   = 1'b0;
                    w_wd_nx     = '0;
                end else if (w_cur_done) begin
                    w_wd_nx = '0;
                    if (r_cur == c_last_idx) begin
                        w_state_nx    = ST_FINISH;
                        w_cur_nx      = '0;
                        w_enable_nx   = '0;
                        w_seq_done_nx = 1'b1;
                    end else begin
                        // Next stage enters on the very next cycle, no gap.
                        w_cur_nx       = r_cur + 1'b1;
                        w_enable_nx    = r_enable << 1;
                        w_start_pls_nx = r_enable << 1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nx     = ST_ERROR;
                    w_cur_nx       = '0;
                    w_enable_nx    = '0;
                    w_busy_nx      = 1'b0;
                    w_terr_nx      = 1'b1;
                    w_err_stage_nx = r_cur;
                    w_wd_nx        = '0;
                end else if (r_wd != '1) begin
                    w_wd_nx = r_wd + 1'b1;
                end
            end

            ST_FINISH: begin
                // FINISH lasts exactly one cycle; abort lands in IDLE too.
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end

            ST_ERROR: begin
                if (bus.clear_err) begin
                    w_state_nx     = ST_IDLE;
                    w_terr_nx      = 1'b0;
                    w_err_stage_nx = '0;
                end
            end

            default: begin
                w_state_nx  = ST_IDLE;
                w_cur_nx    = '0;
                w_enable_nx = '0;
                w_busy_nx   = 1'b0;
            end
        endcase
    end

    assign bus.stage_enable = r_enable;
    assign bus.stage_start  = r_start_pls;
    assign bus.cur_stage    = r_cur;
    assign bus.busy         = r_busy;
    assign bus.seq_done     = r_seq_done;
    assign bus.timeout_err  = r_terr;
    assign bus.err_stage    = r_err_stage;

endmodule

`default_nettype wire
